// File: rtl/usb_drain_pkg.sv
// Shared definitions for the USB data FIFO drain: state encoding and packet counter sizing.
package usb_drain_pkg;

    localparam int unsigned PKT_WORDS = 256;
    localparam int unsigned PKT_CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_PKTEND = 3'd4
    } drain_state_e;

endpackage

// File: rtl/usb_flush_timer.sv
// Idle timer for the drain: counts qualifying idle cycles and pulses expired_c on the terminal count.
// Only built when USB_DRAIN_TIMEOUT_FLUSH_EN is defined.
`ifdef USB_DRAIN_TIMEOUT_FLUSH_EN
module usb_flush_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic Clk,
    input  logic reset,
    input  logic count_en,
    input  logic clr,
    output logic expired_c
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] idle_cnt;
    logic          at_term_c;

    assign at_term_c = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign expired_c = count_en && at_term_c;

    // Count while enabled; a pop restarts the count, the terminal count wraps to zero.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (clr) begin
            idle_cnt <= '0;
        end else if (count_en) begin
            idle_cnt <= at_term_c ? '0 : idle_cnt + TW'(1);
        end
    end

endmodule
`endif

// File: rtl/usb_data_fifo_drain.sv
// Drains the 16-bit USB data FIFO into the USB slave-FIFO bus, one word per four clocks,
// honouring usb_full and issuing PKTEND for a partial packet once a flush is pending and the FIFO is empty.
// Optional: USB_DRAIN_TIMEOUT_FLUSH_EN adds an idle timer that raises a flush automatically.
module usb_data_fifo_drain
    import usb_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
`ifdef USB_DRAIN_TIMEOUT_FLUSH_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  usb_full,
    output logic                  usb_slwr,
    output logic                  usb_pktend,
    output logic [DATA_WIDTH-1:0] usb_fd,
    input  logic                  flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    drain_state_e          state, state_n;
    logic [PKT_CNT_W-1:0]  pkt_cnt, pkt_cnt_n;
    logic                  flush_pend, flush_pend_n;
    logic                  rd_en_n, slwr_n, pktend_n, busy_n;
    logic [DATA_WIDTH-1:0] fd_n;
    logic [CNT_WIDTH-1:0]  words_n;
    logic                  timeout_c;

`ifdef USB_DRAIN_TIMEOUT_FLUSH_EN
    logic timer_en_c;

    assign timer_en_c = (state == ST_IDLE) && fifo_empty && (pkt_cnt != '0) && !flush_pend;

    usb_flush_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_flush_timer (
        .Clk       (Clk),
        .reset     (reset),
        .count_en  (timer_en_c),
        .clr       (rd_en_n),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pkt_cnt    <= '0;
            flush_pend <= 1'b0;
            fifo_rd_en <= 1'b0;
            usb_slwr   <= 1'b0;
            usb_pktend <= 1'b0;
            usb_fd     <= '0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_n;
            pkt_cnt    <= pkt_cnt_n;
            flush_pend <= flush_pend_n;
            fifo_rd_en <= rd_en_n;
            usb_slwr   <= slwr_n;
            usb_pktend <= pktend_n;
            usb_fd     <= fd_n;
            busy       <= busy_n;
            words_sent <= words_n;
        end
    end

    // Next-state and next-output logic; strobes are asserted on entry so they align with the state.
    always_comb begin
        state_n      = state;
        pkt_cnt_n    = pkt_cnt;
        flush_pend_n = flush_pend || flush || timeout_c;
        rd_en_n      = 1'b0;
        slwr_n       = 1'b0;
        pktend_n     = 1'b0;
        fd_n         = usb_fd;
        words_n      = words_sent;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !usb_full) begin
                    state_n = ST_READ;
                    rd_en_n = 1'b1;
                end else if (flush_pend && fifo_empty) begin
                    if (pkt_cnt != '0) begin
                        state_n  = ST_PKTEND;
                        pktend_n = 1'b1;
                    end else begin
                        // Nothing buffered: drop the request rather than send a zero-length packet.
                        flush_pend_n = flush;
                    end
                end
            end
            ST_READ: begin
                state_n = ST_LATCH;
            end
            ST_LATCH: begin
                fd_n    = fifo_dout;
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                if (!usb_full) begin
                    slwr_n    = 1'b1;
                    words_n   = words_sent + CNT_WIDTH'(1);
                    pkt_cnt_n = (pkt_cnt == PKT_CNT_W'(PKT_WORDS - 1)) ? '0 : pkt_cnt + PKT_CNT_W'(1);
                    state_n   = ST_IDLE;
                end
            end
            ST_PKTEND: begin
                pkt_cnt_n    = '0;
                flush_pend_n = flush;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE) || flush_pend_n;
    end

endmodule

// File: tb/tb_usb_data_fifo_drain.sv
// Directed bench for usb_data_fifo_drain: FIFO model, USB bus monitor, vector table plus corner sequences.
module tb_usb_data_fifo_drain;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 32;
    localparam int unsigned TIMEOUT = 4096;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          usb_full = 1'b0;
    logic          usb_slwr;
    logic          usb_pktend;
    logic [DW-1:0] usb_fd;
    logic          flush = 1'b0;
    logic          busy;
    logic [CW-1:0] words_sent;

    usb_data_fifo_drain dut (
        .Clk        (Clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .usb_full   (usb_full),
        .usb_slwr   (usb_slwr),
        .usb_pktend (usb_pktend),
        .usb_fd     (usb_fd),
        .flush      (flush),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int n_words;
        int flush_mode;   // 0 none, 1 after drain, 2 right after loading
        int exp_slwr;
        int exp_pktend;
    } vec_t;

    vec_t          vecs[7];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            slwr_cyc[$];
    int            pkt_cyc[$];
    int            cyc = 0;
    logic          rd_seen = 1'b0;
    int            collide = 0;
    int            underflow = 0;
    int            rd_cnt = 0;
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: model the FIFO pop for last cycle's strobe, then sample the registered outputs.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (rd_seen) begin
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else underflow++;
        end
        fifo_empty = (fifo_q.size() == 0);
        if (usb_slwr) begin
            got_q.push_back(usb_fd);
            slwr_cyc.push_back(cyc);
        end
        if (usb_pktend) pkt_cyc.push_back(cyc);
        if (usb_slwr && usb_pktend) collide++;
        if (fifo_rd_en) rd_cnt++;
        rd_seen = fifo_rd_en;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        slwr_cyc.delete();
        pkt_cyc.delete();
        collide   = 0;
        underflow = 0;
        rd_cnt    = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        usb_full = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        rd_seen  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rd_seen = 1'b0;
        clear_mon();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (k < bound && !(fifo_q.size() == 0 && !busy && !rd_seen)) begin
            tick();
            k++;
        end
        check({name, "_idle_reached"}, 64'(k < bound), 64'd1);
    endtask

    task automatic wait_pop(input string name);
        int k = 0;
        while (!fifo_rd_en && k < 20) begin
            tick();
            k++;
        end
        check({name, "_pop_seen"}, 64'(fifo_rd_en), 64'd1);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bad;
        int rd0;
        int nw;

        vecs[0] = '{n_words: 3,   flush_mode: 0, exp_slwr: 3,   exp_pktend: 0};
        vecs[1] = '{n_words: 256, flush_mode: 1, exp_slwr: 256, exp_pktend: 0};
        vecs[2] = '{n_words: 10,  flush_mode: 1, exp_slwr: 10,  exp_pktend: 1};
        vecs[3] = '{n_words: 5,   flush_mode: 2, exp_slwr: 5,   exp_pktend: 1};
        vecs[4] = '{n_words: 255, flush_mode: 1, exp_slwr: 255, exp_pktend: 1};
        vecs[5] = '{n_words: 257, flush_mode: 1, exp_slwr: 257, exp_pktend: 1};
        vecs[6] = '{n_words: 0,   flush_mode: 1, exp_slwr: 0,   exp_pktend: 0};

        // Reset state
        do_reset();
        check("rst_rd_en",  64'(fifo_rd_en), 64'd0);
        check("rst_slwr",   64'(usb_slwr),   64'd0);
        check("rst_pktend", 64'(usb_pktend), 64'd0);
        check("rst_fd",     64'(usb_fd),     64'd0);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_words",  64'(words_sent), 64'd0);

        // Vector table: load, optional flush, drain, compare the bus trace
        for (int r = 0; r < 7; r++) begin
            do_reset();
            for (int i = 0; i < vecs[r].n_words; i++)
                push_word(DW'(32'h1111 * (i + 1) + r * 7));
            if (vecs[r].flush_mode == 2) pulse_flush();
            wait_idle($sformatf("v%0d_drain", r), vecs[r].n_words * 4 + 40);
            if (vecs[r].flush_mode == 1) begin
                pulse_flush();
                wait_idle($sformatf("v%0d_flush", r), 40);
            end
            repeat (3) tick();

            check($sformatf("v%0d_words_sent", r), 64'(words_sent), 64'(vecs[r].exp_slwr));
            check($sformatf("v%0d_slwr_count", r), 64'(got_q.size()), 64'(vecs[r].exp_slwr));
            check($sformatf("v%0d_pktend_count", r), 64'(pkt_cyc.size()), 64'(vecs[r].exp_pktend));
            bad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) bad++;
            check($sformatf("v%0d_data_order_errs", r), 64'(bad), 64'd0);
            bad = 0;
            for (int i = 1; i < slwr_cyc.size(); i++)
                if (slwr_cyc[i] - slwr_cyc[i-1] != 4) bad++;
            check($sformatf("v%0d_slwr_gap_errs", r), 64'(bad), 64'd0);
            check($sformatf("v%0d_collisions", r), 64'(collide + underflow), 64'd0);
            check($sformatf("v%0d_busy_end", r), 64'(busy), 64'd0);
            if (vecs[r].exp_pktend > 0 && pkt_cyc.size() > 0 && slwr_cyc.size() > 0)
                check($sformatf("v%0d_pktend_after_last_slwr", r),
                      64'(pkt_cyc[0] > slwr_cyc[slwr_cyc.size()-1]), 64'd1);
        end

        // usb_full held in WRITE: no strobe, usb_fd holds, no further pop
        do_reset();
        push_word(16'hABCD);
        push_word(16'h1234);
        wait_pop("full");
        usb_full = 1'b1;
        tick();
        tick();
        rd0 = rd_cnt;
        bad = 0;
        repeat (20) begin
            tick();
            if (usb_fd !== 16'hABCD) bad++;
        end
        check("full_fd_hold_errs", 64'(bad), 64'd0);
        check("full_slwr_count",   64'(got_q.size()), 64'd0);
        check("full_extra_pops",   64'(rd_cnt - rd0), 64'd0);
        usb_full = 1'b0;
        tick();
        check("full_release_slwr", 64'(usb_slwr), 64'd1);
        check("full_release_fd",   64'(usb_fd),   64'hABCD);
        wait_idle("full_tail", 40);
        check("full_total_slwr",  64'(got_q.size()), 64'd2);
        check("full_second_word", 64'(got_q.size() > 1 ? got_q[1] : 16'h0), 64'h1234);
        check("full_words_sent",  64'(words_sent), 64'd2);

        // Reset asserted while stalled in WRITE
        push_word(16'h5A5A);
        wait_pop("rstw");
        usb_full = 1'b1;
        tick();
        tick();
        check("rstw_fd_before", 64'(usb_fd), 64'h5A5A);
        reset = 1'b1;
        #1;
        check("rstw_rd_en",  64'(fifo_rd_en), 64'd0);
        check("rstw_slwr",   64'(usb_slwr),   64'd0);
        check("rstw_pktend", 64'(usb_pktend), 64'd0);
        check("rstw_fd",     64'(usb_fd),     64'd0);
        check("rstw_busy",   64'(busy),       64'd0);
        check("rstw_words",  64'(words_sent), 64'd0);
        tick();
        reset    = 1'b0;
        usb_full = 1'b0;
        rd_seen  = 1'b0;
        clear_mon();
        pulse_flush();
        wait_idle("rstw_flush", 40);
        repeat (3) tick();
        check("rstw_no_pktend_after_reset", 64'(pkt_cyc.size()), 64'd0);
        check("rstw_no_slwr_after_reset",   64'(got_q.size()),   64'd0);

        // Partial packet left idle: timed flush when built with the timer, none otherwise
        do_reset();
        nw = 7;
        for (int i = 0; i < nw; i++) push_word(DW'(16'h0700 + i));
        wait_idle("idle7", nw * 4 + 40);
`ifdef USB_DRAIN_TIMEOUT_FLUSH_EN
        repeat (TIMEOUT + 20) tick();
        check("timeout_pktend_count", 64'(pkt_cyc.size()), 64'd1);
`else
        repeat (300) tick();
        check("idle_no_pktend", 64'(pkt_cyc.size()), 64'd0);
`endif
        check("idle7_slwr_count", 64'(got_q.size()), 64'd7);
        check("idle7_busy_end",   64'(busy), 64'd0);
        check("idle7_collisions", 64'(collide + underflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
